// File: rtl/vlc_bitstream_scheduler_if.sv
// Codeword bus between the three VLC producers, the scheduler and the set_bit
// packer.
//   dc_*  / run_* / lvl_*     : valid/ready codeword channels from the producers
//   lvl_last                  : marks the final AC level codeword of a slice
//   set_bit_*                 : codeword/flush stream to the packer
// The slave modport is the scheduler's view. It accepts codewords on the
// channels and drives the packer stream. The master modport is the opposite
// view, used by the producers and the packer, or by a testbench standing in
// for them.
interface vlc_bitstream_scheduler_if;
  logic        dc_valid;
  logic        dc_ready;
  logic [31:0] dc_val;
  logic [5:0]  dc_size;
  logic        run_valid;
  logic        run_ready;
  logic [31:0] run_val;
  logic [5:0]  run_size;
  logic        lvl_valid;
  logic        lvl_ready;
  logic [31:0] lvl_val;
  logic [5:0]  lvl_size;
  logic        lvl_last;
  logic        set_bit_enable;
  logic [31:0] set_bit_val;
  logic [5:0]  set_bit_size_of_bit;
  logic        set_bit_flush_bit;

  modport slave (
    input  dc_valid, dc_val, dc_size,
    input  run_valid, run_val, run_size,
    input  lvl_valid, lvl_val, lvl_size, lvl_last,
    output dc_ready, run_ready, lvl_ready,
    output set_bit_enable, set_bit_val, set_bit_size_of_bit, set_bit_flush_bit
  );

  modport master (
    output dc_valid, dc_val, dc_size,
    output run_valid, run_val, run_size,
    output lvl_valid, lvl_val, lvl_size, lvl_last,
    input  dc_ready, run_ready, lvl_ready,
    input  set_bit_enable, set_bit_val, set_bit_size_of_bit, set_bit_flush_bit
  );
endinterface

// File: rtl/vlc_bitstream_scheduler.sv
// Shares one set_bit packer among the DC, AC run and AC level VLC producers.
// A slice emits all of its DC codewords first. AC codewords then alternate
// run, level, run, level. The slice ends with one flush pulse, followed by a
// slice_done pulse.
// Ports:
//   clock, reset_n        : clock, async active-low reset
//   slice_start           : start pulse, honoured only in IDLE
//   block_num, ac_none    : slice shape, sampled on an accepted slice_start
//   cw                    : codeword channels and packer stream (interface)
//   busy                  : state != IDLE
//   slice_done            : one-cycle end-of-slice pulse
//   slice_bits            : saturating bit count of the current or last slice
//   size_error            : sticky, set by a codeword longer than MAX_CW
module vlc_bitstream_scheduler #(
  parameter int BLK_W  = 8,
  parameter int BITS_W = 24,
  parameter int MAX_CW = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  slice_start,
  input  logic [BLK_W-1:0]      block_num,
  input  logic                  ac_none,
  vlc_bitstream_scheduler_if.slave cw,
  output logic                  busy,
  output logic                  slice_done,
  output logic [BITS_W-1:0]     slice_bits,
  output logic                  size_error
);

  typedef enum logic [2:0] {S_IDLE, S_DC, S_AC_RUN, S_AC_LVL, S_FLUSH, S_DONE} state_t;

  localparam logic [6:0] MAX_SZ = 7'(MAX_CW);

  state_t            state_q, state_d;
  logic [BLK_W-1:0]  dc_count_q, dc_count_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              ac_none_q, ac_none_d;
  logic              en_q, en_d;
  logic [31:0]       val_q, val_d;
  logic [5:0]        size_q, size_d;
  logic              flush_q, flush_d;
  logic              done_q, done_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic              err_q, err_d;

  logic              x_dc, x_run, x_lvl, x_any;
  logic [31:0]       x_val;
  logic [5:0]        x_size;
  logic [BITS_W:0]   bits_sum;

  // Readies depend only on state, so each state accepts exactly one channel.
  assign cw.dc_ready  = (state_q == S_DC);
  assign cw.run_ready = (state_q == S_AC_RUN);
  assign cw.lvl_ready = (state_q == S_AC_LVL);

  assign x_dc  = cw.dc_valid  & cw.dc_ready;
  assign x_run = cw.run_valid & cw.run_ready;
  assign x_lvl = cw.lvl_valid & cw.lvl_ready;
  assign x_any = x_dc | x_run | x_lvl;

  always_comb begin
    x_val  = cw.dc_val;
    x_size = cw.dc_size;
    if (x_run) begin
      x_val  = cw.run_val;
      x_size = cw.run_size;
    end else if (x_lvl) begin
      x_val  = cw.lvl_val;
      x_size = cw.lvl_size;
    end
  end

  // One extra bit catches the carry so the count saturates instead of wrapping.
  assign bits_sum = {1'b0, bits_q} + {{(BITS_W-5){1'b0}}, x_size};

  always_comb begin
    state_d    = state_q;
    dc_count_d = dc_count_q;
    blk_d      = blk_q;
    ac_none_d  = ac_none_q;
    en_d       = 1'b0;
    val_d      = val_q;
    size_d     = size_q;
    flush_d    = 1'b0;
    done_d     = 1'b0;
    bits_d     = bits_q;
    err_d      = err_q;

    // A zero-size or oversize codeword still advances sequencing, but it is
    // not sent to the packer.
    if (x_any) begin
      if (x_size != 6'd0 && {1'b0, x_size} <= MAX_SZ) begin
        en_d   = 1'b1;
        val_d  = x_val;
        size_d = x_size;
        bits_d = bits_sum[BITS_W] ? {BITS_W{1'b1}} : bits_sum[BITS_W-1:0];
      end else if ({1'b0, x_size} > MAX_SZ) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (slice_start) begin
          bits_d     = '0;
          dc_count_d = '0;
          blk_d      = block_num;
          ac_none_d  = ac_none;
          if (block_num == '0) state_d = ac_none ? S_FLUSH : S_AC_RUN;
          else                 state_d = S_DC;
        end
      end
      S_DC: begin
        if (x_dc) begin
          dc_count_d = dc_count_q + 1'b1;
          if (dc_count_q == blk_q - 1'b1) state_d = ac_none_q ? S_FLUSH : S_AC_RUN;
        end
      end
      S_AC_RUN: if (x_run) state_d = S_AC_LVL;
      S_AC_LVL: if (x_lvl) state_d = cw.lvl_last ? S_FLUSH : S_AC_RUN;
      S_FLUSH: begin
        flush_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dc_count_q <= '0;
      blk_q      <= '0;
      ac_none_q  <= 1'b0;
      en_q       <= 1'b0;
      val_q      <= '0;
      size_q     <= '0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      bits_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dc_count_q <= dc_count_d;
      blk_q      <= blk_d;
      ac_none_q  <= ac_none_d;
      en_q       <= en_d;
      val_q      <= val_d;
      size_q     <= size_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
      bits_q     <= bits_d;
      err_q      <= err_d;
    end
  end

  assign cw.set_bit_enable      = en_q;
  assign cw.set_bit_val         = val_q;
  assign cw.set_bit_size_of_bit = size_q;
  assign cw.set_bit_flush_bit   = flush_q;
  assign busy                   = (state_q != S_IDLE);
  assign slice_done             = done_q;
  assign slice_bits             = bits_q;
  assign size_error             = err_q;

endmodule

// File: tb/tb_vlc_bitstream_scheduler.sv
// Directed test for vlc_bitstream_scheduler. Stimulus pushes the expected
// packer events (enable, flush, done) into a scoreboard queue. A monitor pops
// and compares an entry whenever the DUT presents one of those events.
module tb_vlc_bitstream_scheduler;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        slice_start = 1'b0;
  logic [7:0]  block_num = '0;
  logic        ac_none = 1'b0;
  logic        busy, slice_done, size_error;
  logic [23:0] slice_bits;

  vlc_bitstream_scheduler_if cw();

  vlc_bitstream_scheduler #(.BLK_W(8), .BITS_W(24), .MAX_CW(32)) dut (
    .clock(clock), .reset_n(reset_n), .slice_start(slice_start),
    .block_num(block_num), .ac_none(ac_none), .cw(cw),
    .busy(busy), .slice_done(slice_done), .slice_bits(slice_bits),
    .size_error(size_error)
  );

  always #5 clock = ~clock;

  localparam int K_EN = 0, K_FL = 1, K_DN = 2;
  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [5:0]  size;
    logic [23:0] bits;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t mon_e;
  int   mon_k;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [31:0] v, input logic [5:0] s, input logic [23:0] b);
    exp_t e;
    e.kind = k; e.val = v; e.size = s; e.bits = b;
    sb.push_back(e);
  endtask

  // Monitor: every enable, flush or done pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n && (cw.set_bit_enable || cw.set_bit_flush_bit || slice_done)) begin
      mon_k = cw.set_bit_enable ? K_EN : (cw.set_bit_flush_bit ? K_FL : K_DN);
      chk("event_overlap", 64'((cw.set_bit_enable & cw.set_bit_flush_bit) |
                               (cw.set_bit_enable & slice_done) |
                               (cw.set_bit_flush_bit & slice_done)), 64'd0);
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_unexpected: got event kind %0d expected none at %0t", mon_k, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_kind", 64'(mon_k), 64'(mon_e.kind));
        if (mon_k == K_EN && mon_e.kind == K_EN) begin
          chk("sb_val", 64'(cw.set_bit_val), 64'(mon_e.val));
          chk("sb_size", 64'(cw.set_bit_size_of_bit), 64'(mon_e.size));
        end
        if (mon_k == K_DN && mon_e.kind == K_DN)
          chk("sb_bits", 64'(slice_bits), 64'(mon_e.bits));
      end
    end
  end

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return cw.dc_ready;
      1:       return cw.run_ready;
      default: return cw.lvl_ready;
    endcase
  endfunction

  // Called #1 after a rising edge. Holds the codeword until the channel accepts it.
  task automatic xfer(input int ch, input logic [31:0] v, input logic [5:0] s, input logic last);
    int t;
    t = 0;
    case (ch)
      0:       begin cw.dc_valid = 1'b1;  cw.dc_val = v;  cw.dc_size = s;  end
      1:       begin cw.run_valid = 1'b1; cw.run_val = v; cw.run_size = s; end
      default: begin cw.lvl_valid = 1'b1; cw.lvl_val = v; cw.lvl_size = s; cw.lvl_last = last; end
    endcase
    while (!rdy(ch) && t < 40) begin
      @(posedge clock); #1; t++;
    end
    if (t >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL xfer_timeout: channel %0d ready stayed 0, expected 1", ch);
    end
    @(posedge clock); #1;
    cw.dc_valid = 1'b0; cw.run_valid = 1'b0; cw.lvl_valid = 1'b0; cw.lvl_last = 1'b0;
  endtask

  task automatic start(input logic [7:0] bn, input logic an);
    slice_start = 1'b1; block_num = bn; ac_none = an;
    @(posedge clock); #1;
    slice_start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!slice_done && t < 20) begin
      @(posedge clock); #1; t++;
    end
    if (t >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: slice_done stayed 0, expected 1");
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cw.dc_valid = 0; cw.dc_val = '0; cw.dc_size = '0;
    cw.run_valid = 0; cw.run_val = '0; cw.run_size = '0;
    cw.lvl_valid = 0; cw.lvl_val = '0; cw.lvl_size = '0; cw.lvl_last = 0;

    // Reset state
    #12;
    chk("rst_enable", 64'(cw.set_bit_enable), 0);
    chk("rst_flush", 64'(cw.set_bit_flush_bit), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(slice_done), 0);
    chk("rst_bits", 64'(slice_bits), 0);
    chk("rst_err", 64'(size_error), 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Normal slice. AC valids are held high through the DC phase.
    start(8'd2, 1'b0);
    push(K_EN, 32'h5, 6'd3, 0); push(K_EN, 32'h1A, 6'd5, 0);
    push(K_EN, 32'h2, 6'd2, 0); push(K_EN, 32'h9, 6'd4, 0);
    push(K_FL, 0, 0, 0); push(K_DN, 0, 0, 24'd14);
    cw.dc_valid = 1; cw.dc_val = 32'h5; cw.dc_size = 6'd3;
    cw.run_valid = 1; cw.run_val = 32'h2; cw.run_size = 6'd2;
    cw.lvl_valid = 1; cw.lvl_val = 32'h9; cw.lvl_size = 6'd4; cw.lvl_last = 1;
    chk("t1_dc_ready", 64'(cw.dc_ready), 1);
    chk("t1_run_ready_dc0", 64'(cw.run_ready), 0);
    chk("t1_lvl_ready_dc0", 64'(cw.lvl_ready), 0);
    @(posedge clock); #1;
    cw.dc_val = 32'h1A; cw.dc_size = 6'd5;
    chk("t1_run_ready_dc1", 64'(cw.run_ready), 0);
    chk("t1_lvl_ready_dc1", 64'(cw.lvl_ready), 0);
    chk("t1_en_dc0", 64'(cw.set_bit_enable), 1);
    @(posedge clock); #1;
    cw.dc_valid = 0;
    chk("t1_run_ready", 64'(cw.run_ready), 1);
    chk("t1_size_dc1", 64'(cw.set_bit_size_of_bit), 5);
    @(posedge clock); #1;
    cw.run_valid = 0;
    chk("t1_lvl_ready", 64'(cw.lvl_ready), 1);
    chk("t1_size_run", 64'(cw.set_bit_size_of_bit), 2);
    @(posedge clock); #1;
    cw.lvl_valid = 0; cw.lvl_last = 0;
    chk("t1_size_lvl", 64'(cw.set_bit_size_of_bit), 4);
    wait_done();
    chk("t1_bits", 64'(slice_bits), 14);

    // Empty slice: flush 2 cycles after the start pulse, done 3 cycles after it.
    start(8'd0, 1'b1);
    push(K_FL, 0, 0, 0); push(K_DN, 0, 0, 24'd0);
    chk("t3_flush_c1", 64'(cw.set_bit_flush_bit), 0);
    chk("t3_busy", 64'(busy), 1);
    @(posedge clock); #1;
    chk("t3_flush_c2", 64'(cw.set_bit_flush_bit), 1);
    chk("t3_done_c2", 64'(slice_done), 0);
    @(posedge clock); #1;
    chk("t3_done_c3", 64'(slice_done), 1);
    chk("t3_flush_c3", 64'(cw.set_bit_flush_bit), 0);
    chk("t3_bits", 64'(slice_bits), 0);
    chk("t3_idle", 64'(busy), 0);
    @(posedge clock); #1;

    // Oversize and zero-size codewords: accepted, not sent to the packer.
    start(8'd2, 1'b1);
    push(K_FL, 0, 0, 0); push(K_DN, 0, 0, 24'd0);
    xfer(0, 32'hDEAD, 6'd40, 0);
    xfer(0, 32'hBEEF, 6'd0, 0);
    chk("t4_size_error", 64'(size_error), 1);
    wait_done();
    chk("t4_bits", 64'(slice_bits), 0);

    // A start pulse while busy is ignored. Also covers a size == MAX_CW codeword.
    start(8'd3, 1'b1);
    push(K_EN, 32'h4, 6'd4, 0); push(K_EN, 32'hFFFF_0001, 6'd32, 0);
    push(K_EN, 32'h3, 6'd2, 0); push(K_FL, 0, 0, 0); push(K_DN, 0, 0, 24'd38);
    xfer(0, 32'h4, 6'd4, 0);
    slice_start = 1'b1; block_num = 8'd1;
    @(posedge clock); #1;
    slice_start = 1'b0;
    chk("t6_bits_kept", 64'(slice_bits), 4);
    chk("t6_busy", 64'(busy), 1);
    xfer(0, 32'hFFFF_0001, 6'd32, 0);
    xfer(0, 32'h3, 6'd2, 0);
    wait_done();
    chk("t6_bits", 64'(slice_bits), 38);

    // Reset while in AC_LVL
    start(8'd1, 1'b0);
    push(K_EN, 32'h7F, 6'd7, 0); push(K_EN, 32'h5, 6'd3, 0);
    xfer(0, 32'h7F, 6'd7, 0);
    xfer(1, 32'h5, 6'd3, 0);
    chk("t5_lvl_ready", 64'(cw.lvl_ready), 1);
    cw.lvl_valid = 1; cw.lvl_val = 32'h1; cw.lvl_size = 6'd5; cw.lvl_last = 1;
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("t5_enable", 64'(cw.set_bit_enable), 0);
    chk("t5_val", 64'(cw.set_bit_val), 0);
    chk("t5_size", 64'(cw.set_bit_size_of_bit), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_bits", 64'(slice_bits), 0);
    chk("t5_err", 64'(size_error), 0);
    chk("t5_lvl_ready", 64'(cw.lvl_ready), 0);
    chk("t5_sb_empty", 64'(sb.size()), 0);
    cw.lvl_valid = 0; cw.lvl_last = 0;
    repeat (2) @(posedge clock);
    chk("t5_no_flush", 64'(cw.set_bit_flush_bit), 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    start(8'd1, 1'b1);
    push(K_EN, 32'h2A, 6'd6, 0); push(K_FL, 0, 0, 0); push(K_DN, 0, 0, 24'd6);
    xfer(0, 32'h2A, 6'd6, 0);
    wait_done();
    chk("t5_after_bits", 64'(slice_bits), 6);

    repeat (2) @(posedge clock);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vlc_bitstream_scheduler.md
Name: vlc_bitstream_scheduler

Overview:
- Shares the single set_bit packer among three codeword producers: the DC VLC, the AC run VLC and the AC level VLC.
- Enforces ProRes slice ordering: all DC codewords for the slice first, then AC codewords alternating run, level, run, level.
- At end of slice, issues one flush to the packer, then reports slice completion and the total bit count.
- Sits between the entropy_encode_* blocks and set_bit, under control of the slice sequencer.

Parameters:
- BLK_W, 8, width of block_num (blocks per slice).
- BITS_W, 24, width of the slice_bits counter.
- MAX_CW, 32, largest legal codeword size in bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- slice_start  in  1  one-cycle start pulse; accepted only in IDLE.
- block_num  in  BLK_W  number of DC codewords in the slice; sampled on an accepted slice_start.
- ac_none  in  1  slice has no AC codewords; sampled on an accepted slice_start.
- dc_valid  in  1  DC codeword present.
- dc_ready  out  1  DC codeword accepted this cycle when dc_valid is also high.
- dc_val  in  32  DC codeword, right-justified.
- dc_size  in  6  DC codeword length in bits.
- run_valid, run_ready, run_val, run_size  in/out/in/in  1/1/32/6  AC run channel; same rules as the DC channel.
- lvl_valid, lvl_ready, lvl_val, lvl_size  in/out/in/in  1/1/32/6  AC level channel; same rules as the DC channel.
- lvl_last  in  1  qualifies a level transfer as the last AC codeword of the slice.
- set_bit_enable  out  1  codeword valid to the packer.
- set_bit_val  out  32  codeword to the packer.
- set_bit_size_of_bit  out  6  codeword length to the packer.
- set_bit_flush_bit  out  1  one-cycle flush request to the packer.
- busy  out  1  high when state is not IDLE.
- slice_done  out  1  one-cycle pulse at end of slice.
- slice_bits  out  BITS_W  bits issued in the current or last slice.
- size_error  out  1  sticky; set when a codeword with size > MAX_CW is received.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clock, reset_n). On reset:
  - state=IDLE.
  - set_bit_enable, set_bit_val, set_bit_size_of_bit, set_bit_flush_bit, slice_done, busy, size_error and slice_bits all 0.
  - dc_count=0.
  - Assertion mid-slice aborts immediately; no flush and no slice_done are issued.
- Ready signals are combinational from state only, never from valid:
  - dc_ready = (state==DC).
  - run_ready = (state==AC_RUN).
  - lvl_ready = (state==AC_LVL).
- Transfer = valid & ready. At most one transfer per cycle; the packer never stalls.
- Output path: registered, latency 1.
  - On a transfer with 1 <= size <= MAX_CW: next cycle set_bit_enable=1, with val and size copied; slice_bits += size (saturating at all-ones).
  - Otherwise set_bit_enable=0 and val/size hold their last values.
- size==0: transfer is accepted and counts toward sequencing; no enable, no bits added.
- size > MAX_CW: transfer is accepted and counts toward sequencing; no enable; size_error set (cleared only by reset).
- IDLE:
  - On slice_start: slice_bits<=0, dc_count<=0, sample block_num and ac_none.
  - If block_num==0 go to AC_RUN, or to FLUSH when ac_none=1.
  - Otherwise go to DC.
  - slice_start in any other state is ignored.
- DC: each DC transfer increments dc_count. On the transfer where dc_count==block_num-1:
  - go to FLUSH if ac_none=1;
  - otherwise go to AC_RUN.
- AC_RUN: on a run transfer, go to AC_LVL.
- AC_LVL:
  - Level transfer with lvl_last=1: go to FLUSH.
  - Level transfer with lvl_last=0: go to AC_RUN.
  - lvl_last is ignored when lvl_valid=0.
- FLUSH: lasts exactly one cycle and drives set_bit_flush_bit=1 in the cycle after entry.
  - This never coincides with set_bit_enable=1, because no transfer happens in FLUSH.
  - Then go to DONE.
- DONE: slice_done=1 for one cycle, then go to IDLE. slice_bits holds until the next accepted slice_start.
- Valid on a non-selected channel: not accepted, no effect; the producer holds its codeword.
- dc_count is BLK_W bits wide; block_num=255 gives 255 DC transfers with no wrap.

Test Plan:
- block_num=2, ac_none=0, codewords DC sizes 3,5, run size 2, level size 4 with lvl_last=1, all valids high → packer sees enables of 3,5,2,4 in order on consecutive cycles, then flush, then slice_done; slice_bits=14.
- Raise run_valid and lvl_valid during the DC phase → both readies stay 0 and no AC codeword is issued until both DC transfers complete.
- block_num=0, ac_none=1, pulse slice_start → flush 2 cycles later, slice_done 3 cycles later, slice_bits=0, zero enables.
- DC codeword with size 40 then size 0, block_num=2, ac_none=1 → size_error=1, no enables, sequencing still completes with slice_done.
- Deassert reset_n while in AC_LVL → all outputs 0 asynchronously, IDLE, no flush; a new slice_start after release runs normally.
- slice_start pulsed while busy=1 → ignored; block_num is not re-sampled and slice_bits is not cleared.
